// File: rtl/uart_cmd_assembler.sv
// Pairs bytes from the UART receiver into 16-bit commands (high byte first).
// A partial command is dropped if its low byte does not arrive within TIMEOUT_CLKS.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CLKS = 52080,
  parameter int TMR_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_byte_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE,
    WAIT_LO
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  state_t           state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [7:0]       hi_byte, hi_d;
  logic             complete;
  logic             timeout;

  // Every byte is taken in the cycle it is offered; the receiver drops rdy at the next edge.
  assign clr_byte_rdy = byte_rdy && !rst;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state;
    timer_d  = timer;
    hi_d     = hi_byte;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      IDLE: begin
        if (byte_rdy) begin
          hi_d    = rx_data;
          timer_d = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (timer != '1) timer_d = timer + TMR_W'(1);
        // A byte arriving on the timeout cycle still completes the command.
        if (byte_rdy) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timer == TMR_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      hi_byte     <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      hi_byte     <= hi_d;
      timeout_err <= timeout;

      // A command completing while the consumer acknowledges replaces the old one.
      if (complete && (!cmd_rdy || clr_cmd_rdy)) begin
        cmd     <= {hi_byte, rx_data};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      if (clr_cmd_rdy) overrun <= 1'b0;
      else if (complete && cmd_rdy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: a receiver model drives bytes and
// a scoreboard queue holds the commands expected on the consumer side.
module tb_uart_cmd_assembler;

  localparam int TO = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_byte_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_clr = 0;
  int n_sent = 0;
  int n_to = 0;
  logic [15:0] exp_q[$];
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_cmd = 16'h0;

  uart_cmd_assembler #(.TIMEOUT_CLKS(TO), .TMR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_rdy    (byte_rdy),
    .rx_data     (rx_data),
    .clr_byte_rdy(clr_byte_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte_rdy/clr_byte_rdy is sampled at posedge, where both are stable.
  always @(posedge clk) if (clr_byte_rdy === 1'b1) n_clr++;

  // Consumer side: a newly presented command is popped from the scoreboard.
  always @(negedge clk) begin
    if (timeout_err === 1'b1) n_to++;
    if (cmd_rdy === 1'b1 && (!prev_rdy || cmd !== prev_cmd)) begin
      if (exp_q.size() == 0) check("sb_unexpected_cmd", exp_q.size(), 1);
      else check("sb_cmd", cmd, exp_q.pop_front());
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  // Offer one byte at a negedge; the receiver drops rdy after the consuming edge.
  task automatic send_byte(input logic [7:0] b, input logic clr);
    rx_data     = b;
    byte_rdy    = 1'b1;
    clr_cmd_rdy = clr;
    n_sent++;
    @(posedge clk);
    #1;
    byte_rdy    = 1'b0;
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  int to_base;
  int clr_base;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two bytes 3000 clocks apart.
    clr_base = n_clr;
    send_byte(8'hA5, 1'b0);
    repeat (3000) @(negedge clk);
    check("t1_no_rdy_early", cmd_rdy, 0);
    exp_q.push_back(16'hA53C);
    send_byte(8'h3C, 1'b0);
    check("t1_rdy_latency", cmd_rdy, 1);
    check("t1_cmd", cmd, 16'hA53C);
    check("t1_clr_pulses", n_clr - clr_base, 2);
    clear_cmd();
    check("t1_rdy_cleared", cmd_rdy, 0);
    check("t1_cmd_holds", cmd, 16'hA53C);

    // Lost low byte: exactly one timeout pulse, then alignment restored.
    to_base = n_to;
    send_byte(8'h12, 1'b0);
    repeat (TO - 1) @(negedge clk);
    check("t2_to_before", timeout_err, 0);
    @(negedge clk);
    check("t2_to_pulse", timeout_err, 1);
    @(negedge clk);
    check("t2_to_after", timeout_err, 0);
    check("t2_to_count", n_to - to_base, 1);
    check("t2_no_cmd", cmd_rdy, 0);
    exp_q.push_back(16'h3456);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    check("t2_realigned", cmd, 16'h3456);
    clear_cmd();

    // Low byte on the exact timeout cycle wins.
    to_base = n_to;
    send_byte(8'hAB, 1'b0);
    repeat (TO - 1) @(negedge clk);
    exp_q.push_back(16'hABCD);
    send_byte(8'hCD, 1'b0);
    check("t3_rdy", cmd_rdy, 1);
    check("t3_cmd", cmd, 16'hABCD);
    repeat (3) @(negedge clk);
    check("t3_no_timeout", n_to - to_base, 0);
    clear_cmd();

    // Overrun: second command dropped while the first is pending.
    exp_q.push_back(16'h1111);
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
    check("t4_cmd_kept", cmd, 16'h1111);
    check("t4_overrun", overrun, 1);
    clear_cmd();
    check("t4_rdy_cleared", cmd_rdy, 0);
    check("t4_overrun_cleared", overrun, 0);

    // Acknowledge in the same cycle a new command completes: load wins.
    exp_q.push_back(16'h5566);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    exp_q.push_back(16'h7788);
    send_byte(8'h88, 1'b1);
    check("t5_cmd", cmd, 16'h7788);
    check("t5_rdy", cmd_rdy, 1);
    check("t5_no_overrun", overrun, 0);
    clear_cmd();

    // Reset mid-command with a command pending.
    exp_q.push_back(16'h9999);
    send_byte(8'h99, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_cmd", cmd, 16'h0000);
    check("t6_rst_rdy", cmd_rdy, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_timeout", timeout_err, 0);
    exp_q.push_back(16'h0102);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("t6_cmd", cmd, 16'h0102);
    clear_cmd();

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("clr_total", n_clr, n_sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sequences the UART byte receiver: consumes received bytes via the receiver's rdy/clr_rdy handshake and assembles two consecutive bytes (high byte first) into a 16-bit command.
- Presents the command to the command processor with a level cmd_rdy / clr_cmd_rdy handshake.
- Enforces an inter-byte timeout so a lost byte cannot misalign later commands.
- Flags commands lost because the consumer was not ready.

Parameters:
TIMEOUT_CLKS, 52080, clocks allowed between high-byte capture and low-byte arrival before the partial command is discarded (two byte times at 19200 baud, 50 MHz).
TMR_W, 16, width of the inter-byte timer; must satisfy TIMEOUT_CLKS < 2**TMR_W.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high (the single clock is clk; reset is sampled only on posedge clk)
byte_rdy  input  1  receiver rdy; level, high until cleared
rx_data  input  8  receiver byte; valid while byte_rdy high
clr_byte_rdy  output  1  to receiver clr_rdy; consumes the current byte
cmd  output  16  assembled command {high byte, low byte}
cmd_rdy  output  1  level; command valid
clr_cmd_rdy  input  1  consumer acknowledge; drops cmd_rdy
overrun  output  1  sticky; a completed command was dropped
timeout_err  output  1  one-cycle pulse; partial command discarded

Behaviour:
- Reset (rst high at posedge clk): state=IDLE, timer=0, high-byte reg=0, cmd=16'h0000, cmd_rdy=0, overrun=0, timeout_err=0. Reset mid-command discards the partial byte, and any pending command is dropped.
- clr_byte_rdy is combinational: byte_rdy && !rst, in every state. The receiver's rdy falls at the next edge, so each byte is consumed exactly once. Consumption takes one cycle; there is no back-pressure to the receiver.
- FSM, 2 states:
  - IDLE:
    - byte_rdy -> capture rx_data as high byte; timer<=0; go to WAIT_LO.
    - Otherwise hold. The timer does not count in IDLE.
  - WAIT_LO:
    - Timer increments each cycle.
    - byte_rdy -> form {hi, rx_data} and attempt delivery (rules below); go to IDLE.
    - Else if timer == TIMEOUT_CLKS-1 -> timeout_err=1 for exactly the following cycle; high byte discarded; go to IDLE.
    - byte_rdy in the same cycle as the timeout condition: the byte wins. The command completes and no timeout_err is raised.
- Delivery (registered; cmd/cmd_rdy update at the edge where the low byte is sampled, i.e. 1 clk after byte_rdy is first seen high in WAIT_LO):
  - cmd_rdy==0 -> cmd<={hi,lo}; cmd_rdy<=1.
  - cmd_rdy==1 and clr_cmd_rdy==1 the same cycle -> new command loaded; cmd_rdy stays 1; no overrun.
  - cmd_rdy==1 and clr_cmd_rdy==0 -> new command dropped; cmd unchanged; overrun<=1.
- clr_cmd_rdy with no completion -> cmd_rdy<=0 and overrun<=0 at the next edge. cmd holds its value after clear.
- overrun is cleared only by clr_cmd_rdy or rst. If a new overrun occurs in the same cycle as clr_cmd_rdy, the load-wins rule above applies, so there is no overrun.
- The timer saturates/compares at width TMR_W. Comparison is equality with TIMEOUT_CLKS-1, so no wrap is possible before timeout.

Test Plan:
- Bytes 0xA5 then 0x3C, 3000 clks apart -> cmd=16'hA53C, cmd_rdy rises 1 clk after the second byte_rdy; clr_byte_rdy is exactly one pulse per byte; clr_cmd_rdy -> cmd_rdy=0 next clk, cmd holds 16'hA53C.
- Byte 0x12, then nothing for TIMEOUT_CLKS clks -> single timeout_err pulse, no cmd_rdy; then 0x34, 0x56 -> cmd=16'h3456 (alignment restored).
- Low byte arrives on the exact timeout cycle -> no timeout_err; cmd built from both bytes.
- cmd=16'h1111 pending, second command 0x22,0x22 with no clear -> cmd stays 16'h1111, overrun=1; clr_cmd_rdy -> cmd_rdy=0, overrun=0.
- clr_cmd_rdy in the same cycle a new command 0x7788 completes -> cmd=16'h7788, cmd_rdy=1, overrun=0.
- rst asserted in WAIT_LO after high byte 0xFF, then 0x01,0x02 -> all outputs 0 after reset; resulting cmd=16'h0102.
